// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader / unified memory block.
// Opcode values mirror the core's instruction decoder.
package program_loader_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] OP_SUB   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_LOAD  = 3'd6;
  localparam logic [2:0] OP_STORE = 3'd7;

  function automatic logic [5:0] clamp_len(input logic [5:0] len);
    return (len > 6'd32) ? 6'd32 : len;
  endfunction

endpackage

// File: rtl/mem_array_32x8.sv
// 32x8 register-file memory: one synchronous write port, two combinational
// read ports, cleared asynchronously on reset.
module mem_array_32x8
  import program_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/program_loader_mem.sv
// Program loader plus unified memory feeding the CPU core: streams in an image,
// zero-fills the tail, then runs the core for a bounded cycle budget.
//
// state | meaning
// IDLE  | waiting for load_start, core held in reset
// LOAD  | accepting image bytes into mem[wp]
// CLEAR | zero-filling mem[wp..31]
// RUN   | core released and owns the memory bus
// DONE  | budget exhausted, memory retained, core in reset
module program_loader_mem
  import program_loader_pkg::*;
#(
  parameter int CYCLE_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_start,
  input  logic [5:0]         load_len,
  input  logic               load_valid,
  input  logic [DATA_W-1:0]  load_data,
  output logic               load_ready,
  input  logic [CYCLE_W-1:0] run_cycles,
  input  logic               abort,
  output logic               core_reset,
  output logic               start_execution,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_write,
  input  logic [DATA_W-1:0]  mem_write_data,
  output logic [DATA_W-1:0]  mem_read_data,
  input  logic [ADDR_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic               busy,
  output logic               done,
  output logic [CYCLE_W-1:0] cycle_count
);

  state_e             state_q, state_d;
  logic [5:0]         len_q;
  logic [5:0]         wp_q;
  logic [5:0]         wp_inc;
  logic [CYCLE_W-1:0] budget_q;
  logic [CYCLE_W-1:0] remain_q;
  logic [CYCLE_W-1:0] cycle_count_q;
  logic               load_ready_q, core_reset_q, start_execution_q, busy_q, done_q;
  logic               accept_start;
  logic               wp_advance;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;

  assign wp_inc = wp_q + 6'd1;

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (load_start) begin
            accept_start = 1'b1;
            state_d      = (clamp_len(load_len) == 6'd0) ? ST_CLEAR : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_valid && (wp_inc == len_q))
            state_d = (len_q == 6'd32) ? ST_RUN : ST_CLEAR;
        end
        ST_CLEAR: begin
          if (wp_q[ADDR_W-1:0] == 5'd31) state_d = ST_RUN;
        end
        ST_RUN: begin
          if ((budget_q != '0) && (remain_q == CYCLE_W'(1))) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Single write port: loader owns it in LOAD/CLEAR, the core only in RUN;
  // an abort cycle writes nothing so the aborted image tail is retained.
  always_comb begin
    mem_we     = 1'b0;
    mem_waddr  = wp_q[ADDR_W-1:0];
    mem_wdata  = '0;
    wp_advance = 1'b0;
    if (!abort) begin
      case (state_q)
        ST_LOAD: begin
          mem_we     = load_valid;
          mem_wdata  = load_data;
          wp_advance = load_valid;
        end
        ST_CLEAR: begin
          mem_we     = 1'b1;
          wp_advance = 1'b1;
        end
        ST_RUN: begin
          mem_we    = mem_write;
          mem_waddr = mem_addr;
          mem_wdata = mem_write_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      len_q             <= '0;
      wp_q              <= '0;
      budget_q          <= '0;
      remain_q          <= '0;
      cycle_count_q     <= '0;
      load_ready_q      <= 1'b0;
      core_reset_q      <= 1'b1;
      start_execution_q <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      load_ready_q      <= (state_d == ST_LOAD);
      core_reset_q      <= (state_d != ST_RUN);
      start_execution_q <= (state_d == ST_RUN);
      busy_q            <= (state_d == ST_LOAD) || (state_d == ST_CLEAR) || (state_d == ST_RUN);
      done_q            <= (state_d == ST_DONE);

      if (accept_start) begin
        len_q         <= clamp_len(load_len);
        budget_q      <= run_cycles;
        wp_q          <= '0;
        cycle_count_q <= '0;
      end else if (wp_advance) begin
        wp_q <= wp_inc;
      end

      if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
        cycle_count_q <= '0;
        remain_q      <= budget_q;
      end else if ((state_q == ST_RUN) && !abort) begin
        cycle_count_q <= cycle_count_q + CYCLE_W'(1);
        remain_q      <= remain_q - CYCLE_W'(1);
      end
    end
  end

  mem_array_32x8 u_mem (
    .clock     (clock),
    .reset     (reset),
    .we_i      (mem_we),
    .waddr_i   (mem_waddr),
    .wdata_i   (mem_wdata),
    .raddr_a_i (mem_addr),
    .rdata_a_o (mem_read_data),
    .raddr_b_i (dbg_addr),
    .rdata_b_o (dbg_data)
  );

  assign load_ready      = load_ready_q;
  assign core_reset      = core_reset_q;
  assign start_execution = start_execution_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign cycle_count     = cycle_count_q;

endmodule

// File: tb/tb_program_loader_mem.sv
// Directed bench for program_loader_mem: load/stall, zero-fill, budget,
// core stores, abort and mid-load reset, checked against a bench-side memory image.
module tb_program_loader_mem;

  logic        clock;
  logic        reset;
  logic        load_start;
  logic [5:0]  load_len;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic [15:0] run_cycles;
  logic        abort;
  logic        core_reset;
  logic        start_execution;
  logic [4:0]  mem_addr;
  logic        mem_write;
  logic [7:0]  mem_write_data;
  logic [7:0]  mem_read_data;
  logic [4:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic        busy;
  logic        done;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_mem [32];

  program_loader_mem #(.CYCLE_W(16)) dut (
    .clock           (clock),
    .reset           (reset),
    .load_start      (load_start),
    .load_len        (load_len),
    .load_valid      (load_valid),
    .load_data       (load_data),
    .load_ready      (load_ready),
    .run_cycles      (run_cycles),
    .abort           (abort),
    .core_reset      (core_reset),
    .start_execution (start_execution),
    .mem_addr        (mem_addr),
    .mem_write       (mem_write),
    .mem_write_data  (mem_write_data),
    .mem_read_data   (mem_read_data),
    .dbg_addr        (dbg_addr),
    .dbg_data        (dbg_data),
    .busy            (busy),
    .done            (done),
    .cycle_count     (cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk($sformatf("%s[%0d]", tag, i), {24'd0, dbg_data}, {24'd0, exp_mem[i]});
    end
  endtask

  initial begin
    int hi;
    int n;
    reset = 1'b1; load_start = 1'b0; load_len = '0; load_valid = 1'b0; load_data = '0;
    run_cycles = '0; abort = 1'b0; mem_addr = '0; mem_write = 1'b0; mem_write_data = '0;
    dbg_addr = '0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h00;

    // Reset values
    tick(); tick();
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("rst_start_exec", {31'd0, start_execution}, 32'd0);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cycle_count", {16'd0, cycle_count}, 32'd0);
    reset = 1'b0;
    check_mem("rst_mem");

    // Load len=4 with a 2-cycle stall, budget 10
    load_start = 1'b1; load_len = 6'd4; run_cycles = 16'd10;
    tick();
    load_start = 1'b0;
    chk("load_ready_on", {31'd0, load_ready}, 32'd1);
    chk("load_busy", {31'd0, busy}, 32'd1);
    load_valid = 1'b1; load_data = 8'hCD; tick();
    load_data = 8'h2A; tick();
    load_valid = 1'b0; tick(); tick();
    chk("stall_ready", {31'd0, load_ready}, 32'd1);
    load_valid = 1'b1; load_data = 8'h00; tick();
    load_data = 8'h7F; tick();
    load_valid = 1'b0;
    chk("clear_entry_ready", {31'd0, load_ready}, 32'd0);
    chk("clear_entry_busy", {31'd0, busy}, 32'd1);
    repeat (27) tick();
    chk("clear_27_not_run", {31'd0, start_execution}, 32'd0);
    tick();
    chk("run_entry_28", {31'd0, start_execution}, 32'd1);
    chk("run_core_reset", {31'd0, core_reset}, 32'd0);
    exp_mem[0] = 8'hCD; exp_mem[1] = 8'h2A; exp_mem[2] = 8'h00; exp_mem[3] = 8'h7F;

    // Core store in RUN: same-cycle read sees old value
    mem_addr = 5'd6; mem_write_data = 8'h5A; mem_write = 1'b1;
    #1;
    chk("store_read_old", {24'd0, mem_read_data}, 32'h00);
    tick();
    mem_write = 1'b0;
    dbg_addr = 5'd6;
    #1;
    chk("store_dbg_new", {24'd0, dbg_data}, 32'h5A);
    chk("store_read_new", {24'd0, mem_read_data}, 32'h5A);
    chk("run_cycle_count_1", {16'd0, cycle_count}, 32'd1);
    exp_mem[6] = 8'h5A;
    hi = 2;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (start_execution) hi++;
      else break;
    end
    chk("budget_run_len", hi, 32'd10);
    chk("budget_done", {31'd0, done}, 32'd1);
    chk("budget_cycle_count", {16'd0, cycle_count}, 32'd10);
    chk("done_core_reset", {31'd0, core_reset}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);

    // Core write in DONE must be ignored
    mem_addr = 5'd6; mem_write_data = 8'hA5; mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    check_mem("after_stall_load");

    // Fill with FF via len=40 (clamps to 32, straight to RUN), budget 1
    load_start = 1'b1; load_len = 6'd40; run_cycles = 16'd1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'hFF;
    repeat (32) tick();
    load_valid = 1'b0;
    chk("len32_run", {31'd0, start_execution}, 32'd1);
    chk("len32_ready_off", {31'd0, load_ready}, 32'd0);
    tick();
    chk("len32_done", {31'd0, done}, 32'd1);
    chk("len32_cycle_count", {16'd0, cycle_count}, 32'd1);
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'hFF;
    check_mem("ff_fill");

    // Stale data: short reload must zero everything past the image
    load_start = 1'b1; load_len = 6'd2; run_cycles = 16'd3;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'h11; tick();
    load_data = 8'h22; tick();
    load_valid = 1'b0;
    for (int i = 0; i < 100 && !done; i++) tick();
    chk("stale_done", {31'd0, done}, 32'd1);
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h00;
    exp_mem[0] = 8'h11; exp_mem[1] = 8'h22;
    check_mem("stale");

    // Abort in CLEAR at wp=10, with a simultaneous load_start
    load_start = 1'b1; load_len = 6'd32; run_cycles = 16'd1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      load_data = 8'h40 + 8'(i);
      tick();
    end
    load_valid = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h40 + 8'(i);
    load_start = 1'b1; load_len = 6'd2; run_cycles = 16'd5;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'hAA; tick();
    load_data = 8'hBB; tick();
    load_valid = 1'b0;
    repeat (8) tick();
    abort = 1'b1; load_start = 1'b1; load_len = 6'd0;
    tick();
    abort = 1'b0; load_start = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_core_reset", {31'd0, core_reset}, 32'd1);
    chk("abort_ready", {31'd0, load_ready}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    tick();
    chk("abort_start_ignored", {31'd0, busy}, 32'd0);
    exp_mem[0] = 8'hAA; exp_mem[1] = 8'hBB;
    for (int i = 2; i < 10; i++) exp_mem[i] = 8'h00;
    check_mem("abort_clear");

    // Reset mid-LOAD after 3 bytes
    load_start = 1'b1; load_len = 6'd8; run_cycles = 16'd0;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data = 8'h01; tick();
    load_data = 8'h02; tick();
    load_data = 8'h03; tick();
    chk("midload_ready", {31'd0, load_ready}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, load_ready}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h00;
    check_mem("midrst_mem");
    load_valid = 1'b0;
    tick();
    reset = 1'b0;

    // len=0: full 32-cycle clear, unlimited budget
    load_start = 1'b1; load_len = 6'd0; run_cycles = 16'd0;
    tick();
    load_start = 1'b0;
    chk("len0_busy", {31'd0, busy}, 32'd1);
    chk("len0_ready", {31'd0, load_ready}, 32'd0);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (start_execution) break;
      tick();
      n++;
    end
    chk("len0_clear_cycles", n, 32'd32);
    load_start = 1'b1; load_len = 6'd5; run_cycles = 16'd3;
    tick();
    load_start = 1'b0;
    chk("start_in_run_ignored", {31'd0, start_execution}, 32'd1);
    chk("start_in_run_ready", {31'd0, load_ready}, 32'd0);
    repeat (1000) tick();
    chk("unlimited_still_run", {31'd0, start_execution}, 32'd1);
    chk("unlimited_not_done", {31'd0, done}, 32'd0);
    chk("unlimited_cycle_count", {16'd0, cycle_count}, 32'd1001);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("run_abort_start_exec", {31'd0, start_execution}, 32'd0);
    chk("run_abort_core_reset", {31'd0, core_reset}, 32'd1);
    chk("run_abort_busy", {31'd0, busy}, 32'd0);
    chk("run_abort_count_hold", {16'd0, cycle_count}, 32'd1001);
    check_mem("len0_mem");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader_mem.md
# program_loader_mem

Unified program/data memory plus byte-stream program loader sitting directly upstream of the CPU core. The block accepts a program image over a valid/ready byte stream and zero-fills the unused tail. It then releases the core and serves its fetch, load and store accesses from a single array for a bounded cycle budget. It drives the core's `reset` and `start_execution` inputs and owns the core's memory bus.

## Interface
- `ADDR_W`, 5: memory address width. Depth is 2^ADDR_W = 32.
- `DATA_W`, 8: byte width.
- `CYCLE_W`, 16: width of the run budget and cycle counter.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `load_start` in 1: begin a load. Accepted only in IDLE or DONE.
- `load_len` in 6: number of image bytes. Sampled on an accepted `load_start`. Values >32 clamp to 32.
- `load_valid` in 1: image byte valid.
- `load_data` in 8: image byte.
- `load_ready` out 1: high in LOAD.
- `run_cycles` in CYCLE_W: RUN budget, sampled on an accepted `load_start`. 0 means unlimited.
- `abort` in 1: force IDLE from any state.
- `core_reset` out 1: registered reset to the core, high in every state except RUN.
- `start_execution` out 1: registered, high only in RUN.
- `mem_addr` in 5, `mem_write` in 1, `mem_write_data` in 8: core bus.
- `mem_read_data` out 8: combinational read, equal to mem[`mem_addr`].
- `dbg_addr` in 5 / `dbg_data` out 8: combinational second read port for the testbench and host.
- `busy` out 1: high in LOAD, CLEAR and RUN.
- `done` out 1: high in DONE.
- `cycle_count` out CYCLE_W: RUN cycles elapsed. Holds its value in DONE and clears on an accepted `load_start`.

## Operation
States: IDLE, LOAD, CLEAR, RUN, DONE.

IDLE/DONE:
- On `load_start`, latch `len` (clamped) and the budget, and set the write pointer `wp` to 0.
- If `len` is 0 go to CLEAR, otherwise go to LOAD.

LOAD:
- `load_ready`=1.
- Each `load_valid & load_ready` edge writes `load_data` to mem[`wp`] and increments `wp`.
- After the transfer that makes `wp` equal `len`:
  - if `len` is 32, go to RUN;
  - otherwise go to CLEAR.

CLEAR:
- Each cycle writes 0 to mem[`wp`] and increments `wp`.
- After writing address 31, go to RUN.
- Old program bytes must never survive a new load.

RUN:
- Entry clears `cycle_count` to 0; `cycle_count` then increments every cycle.
- The core owns the bus: `mem_write`=1 writes `mem_write_data` to mem[`mem_addr`] at the edge.
- If the budget B≠0, RUN lasts exactly B cycles, then the block goes to DONE.
- With B=0, RUN continues until `abort`.

DONE:
- Memory contents are retained and readable via `dbg_*`.
- `core_reset`=1.

`abort`:
- Highest priority. The next state is IDLE.
- Memory is retained and `cycle_count` holds.
- `load_start` in the same cycle as `abort` is ignored.

Other rules:
- `load_start` is ignored in LOAD, CLEAR and RUN.
- Core `mem_write` is ignored outside RUN. The core is held in reset then, so no core write is expected.
- Address arithmetic is modulo 32. `wp` is 6 bits so that the value 32 can be detected.

## Timing
- Reset values:
  - state IDLE;
  - `core_reset`=1;
  - `start_execution`=0, `load_ready`=0, `busy`=0, `done`=0;
  - `cycle_count`=0;
  - all 32 memory bytes 0.
- Read latency is 0 cycles: `mem_read_data` and `dbg_data` follow their address combinationally. This matches the core, which registers `mem_addr` one cycle before consuming the data.
- Writes take effect at the edge. A read of the same address in the same cycle returns the old value.
- Load cost: `len` transfer cycles (with `load_valid` held) plus (32−`len`) CLEAR cycles.
- `start_execution` and `core_reset` change on the same edge that enters or leaves RUN.
- Reset asserted mid-LOAD or mid-RUN returns the block to its reset values immediately.

## Structure
- Package `program_loader_pkg` holds:
  - the state enum;
  - `ADDR_W`, `DATA_W`, `MEM_DEPTH`=32;
  - the opcode constants shared with the core (SUB=0, ADD=1, AND=2, OR=3, XOR=4, LOAD=6, STORE=7).
- Sub-module `mem_array_32x8` provides:
  - one write port, muxed between loader and core by state;
  - two combinational read ports;
  - asynchronous clear on reset.

## Test plan
- Reset: assert `reset` mid-LOAD after 3 bytes → `core_reset`=1, state IDLE, `dbg_data`=0 at all 32 addresses.
- Load with stall:
  - stimulus: `len`=4, bytes CD,2A,00,7F, with `load_valid` low for 2 cycles between bytes 2 and 3;
  - response: exactly 4 writes, mem[0..3] as given, mem[4..31]=0;
  - RUN entered 28 cycles after the last transfer, and `start_execution` rises on that same edge.
- Stale data: load 32 bytes of FF, then load `len`=2 (11,22) → mem[0..1]=11,22 and every other address reads 0.
- Budget:
  - `run_cycles`=10 → `start_execution` high for exactly 10 cycles, then `done`=1, `cycle_count`=10;
  - `run_cycles`=0 → still RUN after 1000 cycles.
- Core store in RUN: bench drives `mem_addr`=6, `mem_write`=1, data 5A → `dbg_data` at address 6 reads 5A next cycle; the same write driven in DONE leaves mem[6] unchanged.
- Abort:
  - `abort` in CLEAR at `wp`=10 → IDLE next cycle, mem[10..31] unchanged;
  - `load_start` with `abort` in the same cycle is ignored;
  - `load_start` in RUN is ignored.
